// File: rtl/matdet4_seq.sv
// Sequenced 4x4 determinant: cofactor expansion along row 0 using one shared
// 3x3 determinant unit and one multiplier, one column every two cycles.

module mul #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] p
);
    assign p = x * y;
endmodule

module matdet3 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [9*DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH-1:0]   d
);
    logic [DATA_WIDTH-1:0] w_e [9];
    logic [DATA_WIDTH-1:0] w_c0, w_c1, w_c2;

    always_comb begin
        for (int i = 0; i < 9; i++) w_e[i] = m[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // a(ei-fh) - b(di-fg) + c(dh-eg), all truncated to DATA_WIDTH
    assign w_c0 = w_e[4]*w_e[8] - w_e[5]*w_e[7];
    assign w_c1 = w_e[3]*w_e[8] - w_e[5]*w_e[6];
    assign w_c2 = w_e[3]*w_e[7] - w_e[4]*w_e[6];
    assign d    = w_e[0]*w_c0 - w_e[1]*w_c1 + w_e[2]*w_c2;
endmodule

module matdet4_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0]    det,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MINOR = 2'd1;
    localparam logic [1:0] S_ACC   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               r_col;
    logic [16*DATA_WIDTH-1:0] r_m;
    logic [DATA_WIDTH-1:0]    r_minor;
    logic [DATA_WIDTH-1:0]    r_acc;
    logic [DATA_WIDTH-1:0]    r_det;

    logic [9*DATA_WIDTH-1:0]  w_minor_m;
    logic [DATA_WIDTH-1:0]    w_minor_d;
    logic [DATA_WIDTH-1:0]    w_elem;
    logic [DATA_WIDTH-1:0]    w_prod;
    logic [DATA_WIDTH-1:0]    w_sum;

    // Minor for column r_col: rows 1..3, skipping source column r_col
    always_comb begin
        int v_src;
        w_minor_m = '0;
        w_elem    = '0;
        for (int r = 1; r < 4; r++) begin
            for (int j = 0; j < 3; j++) begin
                v_src = (j < int'(r_col)) ? j : j + 1;
                w_minor_m[((r-1)*3+j)*DATA_WIDTH +: DATA_WIDTH] =
                    r_m[(4*r+v_src)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (r_col == 2'(c)) w_elem = r_m[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    matdet3 #(.DATA_WIDTH(DATA_WIDTH)) u_det3 (.m(w_minor_m), .d(w_minor_d));
    mul     #(.DATA_WIDTH(DATA_WIDTH)) u_mul  (.x(w_elem), .y(r_minor), .p(w_prod));

    // Odd columns carry a negative cofactor sign
    assign w_sum = r_col[0] ? (r_acc - w_prod) : (r_acc + w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= 2'd0;
            r_acc   <= '0;
            r_det   <= '0;
            r_minor <= '0;
            r_m     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m     <= a;
                        r_acc   <= '0;
                        r_col   <= 2'd0;
                        r_state <= S_MINOR;
                    end
                end
                S_MINOR: begin
                    r_minor <= w_minor_d;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_acc <= w_sum;
                    if (r_col == 2'd3) begin
                        r_det   <= w_sum;
                        r_state <= S_DONE;
                    end else begin
                        r_col   <= r_col + 2'd1;
                        r_state <= S_MINOR;
                    end
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign det       = r_det;
endmodule

// File: tb/tb_matdet4_seq.sv
// Randomized and directed checks of matdet4_seq against a permutation-sum
// (Leibniz) determinant model taken modulo 2^8.

module tb_matdet4_seq;
    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [16*W-1:0] a;
    logic [W-1:0]    det;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    matdet4_seq #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .det(det), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [16*W-1:0] pack(input int v[16]);
        logic [16*W-1:0] m;
        for (int i = 0; i < 16; i++) m[i*W +: W] = v[i][W-1:0];
        return m;
    endfunction

    function automatic logic [W-1:0] ref_det(input logic [16*W-1:0] m);
        longint sum = 0;
        longint prod;
        int p [4];
        int inv;
        for (int p0 = 0; p0 < 4; p0++)
        for (int p1 = 0; p1 < 4; p1++)
        for (int p2 = 0; p2 < 4; p2++)
        for (int p3 = 0; p3 < 4; p3++) begin
            if (p0 != p1 && p0 != p2 && p0 != p3 && p1 != p2 && p1 != p3 && p2 != p3) begin
                p = '{p0, p1, p2, p3};
                inv = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = i + 1; j < 4; j++)
                        if (p[i] > p[j]) inv++;
                prod = 1;
                for (int r = 0; r < 4; r++)
                    prod = prod * longint'(m[(4*r+p[r])*W +: W]);
                sum = (inv % 2 == 0) ? sum + prod : sum - prod;
            end
        end
        return sum[W-1:0];
    endfunction

    function automatic logic [16*W-1:0] rnd_mat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present m and return just after the accepting edge
    task automatic accept(input logic [16*W-1:0] m);
        bit ok = 0;
        a = m;
        in_valid = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    // Wait for out_valid; latency counts edges after the accept edge
    task automatic get_result(input string tag, input logic [W-1:0] exp, input bit chk_lat);
        int lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && chk_lat) chk({tag, "_busy"}, {31'd0, busy}, 1);
            if (out_valid) lat = k;
        end
        if (lat == 0) chk({tag, "_timeout"}, 0, 1);
        if (chk_lat) chk({tag, "_lat"}, lat, 8);
        chk({tag, "_det"}, {24'd0, det}, {24'd0, exp});
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({tag, "_ov1cyc"}, {31'd0, out_valid}, 0);
            chk({tag, "_rdy"}, {31'd0, in_ready}, 1);
        end
    endtask

    initial begin
        int tv [16];
        logic [16*W-1:0] m_id, m_ut, m_sw, m_d4, m_one, cur, d_s;
        logic [W-1:0] exp_q [$];
        logic [W-1:0] d;
        bit hs_in, hs_out, seen;
        int sent, got, last_acc;

        tv = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1}; m_id = pack(tv);
        tv = '{1,2,3,4, 0,2,5,6, 0,0,3,7, 0,0,0,1}; m_ut = pack(tv);
        tv = '{0,1,0,0, 1,0,0,0, 0,0,1,0, 0,0,0,1}; m_sw = pack(tv);
        tv = '{4,0,0,0, 0,4,0,0, 0,0,4,0, 0,0,0,4}; m_d4 = pack(tv);
        tv = '{1,1,1,1, 1,1,1,1, 1,1,1,1, 1,1,1,1}; m_one = pack(tv);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_det", {24'd0, det}, 0);

        accept(m_id);  get_result("ident", 8'h01, 1);
        accept(m_ut);  get_result("uptri", 8'd6, 1);
        accept(m_sw);  get_result("swap", 8'hFF, 1);
        accept(m_d4);  get_result("diag4", 8'h00, 1);
        accept(m_one); get_result("ones", 8'h00, 1);

        // Backpressure in DONE with a competing input
        out_ready = 1'b0;
        accept(m_ut);
        get_result("bp_first", 8'd6, 1);
        a = m_sw; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_det", {24'd0, det}, 6);
            chk("bp_ov", {31'd0, out_valid}, 1);
            chk("bp_rdy", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        accept(m_sw);
        get_result("bp_second", 8'hFF, 1);

        // Abort mid-computation
        accept(m_ut);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_ov", {31'd0, out_valid}, 0);
        chk("abort_det", {24'd0, det}, 0);
        chk("abort_rdy", {31'd0, in_ready}, 1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_result", {31'd0, seen}, 0);
        accept(m_id); get_result("abort_ident", 8'h01, 1);

        // Back-to-back random matrices with random consumer stalls
        sent = 0; got = 0; last_acc = -100;
        cur = rnd_mat();
        for (int t = 0; t < 3000 && got < 8; t++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            a = cur;
            in_valid = (sent < 8);
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            d = det;
            @(posedge clk);
            if (hs_in) begin
                if (sent > 0) chk("b2b_gap", {31'd0, (t - last_acc) >= 10}, 1);
                exp_q.push_back(ref_det(cur));
                last_acc = t;
                sent++;
                cur = rnd_mat();
            end
            if (hs_out) begin
                if (exp_q.size() == 0) chk("b2b_extra", 1, 0);
                else chk("b2b_det", {24'd0, d}, {24'd0, exp_q.pop_front()});
                got++;
            end
        end
        #1 in_valid = 1'b0;
        chk("b2b_count", got, 8);
        chk("b2b_pending", exp_q.size(), 0);

        // Random single-shot matrices at full rate on the output side
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_s = rnd_mat();
            accept(d_s);
            get_result("rand", ref_det(d_s), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
